cp0_unit: RTL

- Coprocessor-0 and exception unit of the 5-stage MIPS CPU.
- Sits beside the EXE stage and consumes the decoder's cp_oper for MTC0 and ERET, and supplies MFC0 read data through the EXE_A_INT operand path.
- Samples an external interrupt line and decides when the interrupt is safe to take.
- Produces the one-cycle jump_en / jump_addr redirect that the pipeline controller uses to flush ID and steer PC.

---
 rtl/cp0_pkg.sv | 47 ++++
 rtl/cp0_irq_sync.sv | 34 +++
 rtl/cp0_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_pkg
// Purpose  : Shared CP0 definitions: register indices, bit positions, EXE
//            cp_oper codes (also used by the pipeline controller), FSM state
//            type and the per-register MTC0 write mask.
// Revision : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register indices (rd field of MFC0/MTC0)
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;
    localparam logic [4:0] CP0_REG_EBASE  = 5'd15;

    // Bit positions inside STATUS and CAUSE
    localparam int STATUS_IE = 0;
    localparam int CAUSE_IP  = 10;

    // cp_oper codes produced by the decoder for the EXE stage
    localparam logic [1:0] EXE_CP_NONE  = 2'd0;
    localparam logic [1:0] EXE_CP_STORE = 2'd1;
    localparam logic [1:0] EXE_CP0_ERET = 2'd2;

    typedef enum logic [1:0] {
        CP0_IDLE    = 2'd0,
        CP0_PEND    = 2'd1,
        CP0_HANDLER = 2'd2
    } cp0_state_t;

    // Bits of each register that MTC0 may change. CAUSE is read-only and
    // unimplemented indices accept nothing, so both return an empty mask.
    function automatic logic [31:0] cp0_wmask(input logic [4:0] idx);
        logic [31:0] m;
        m = 32'h0000_0000;
        case (idx)
            CP0_REG_STATUS: m[STATUS_IE] = 1'b1;
            CP0_REG_EPC:    m = 32'hFFFF_FFFF;
            CP0_REG_EBASE:  m = 32'hFFFF_FFFC;
            default:        m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : cp0_irq_sync
// Purpose  : Synchronises the asynchronous interrupt request and produces a
//            one-cycle pulse on each rising edge of the synchronised level.
// Ports    : clk, rst (async active-low), ir_in (async level),
//            irq_edge (one-cycle pulse, combinational from flops).
// Revision : 1.0 - initial release
// ============================================================================
module cp0_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic irq_edge
);

    // Bits [SYNC_STAGES-1:0] form the synchroniser chain; the extra top bit
    // holds the previous synchronised level for the edge detector.
    logic [SYNC_STAGES:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], ir_in};
        end
    end

    assign irq_edge = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_unit
// Purpose  : Coprocessor-0 and interrupt/exception unit beside the EXE stage.
//            Holds STATUS/CAUSE/EPC/EBASE, serves MFC0 reads, performs MTC0
//            writes, decides when a pending interrupt may be taken and issues
//            the registered one-cycle PC redirect for interrupt entry / ERET.
// Ports    : clk, rst (async active-low), en (EXE enable),
//            oper (cp_oper), addr_r/data_r (MFC0), addr_w/data_w (MTC0),
//            ret_addr (EXE PC), exe_valid, is_branch_exe, is_branch_mem,
//            ir_in (async interrupt), jump_en/jump_addr (redirect),
//            in_handler (inside interrupt handler).
// Revision : 1.0 - initial release
// ============================================================================
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EBASE_RST   = 32'h0000_0004,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  oper,
    input  logic [4:0]  addr_r,
    output logic [31:0] data_r,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    input  logic [31:0] ret_addr,
    input  logic        exe_valid,
    input  logic        is_branch_exe,
    input  logic        is_branch_mem,
    input  logic        ir_in,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        in_handler
);

    cp0_state_t  state;
    cp0_state_t  state_nxt;

    logic        status_ie;
    logic        cause_ip;
    logic [31:0] epc;
    logic [31:0] ebase;

    logic        irq_edge;
    logic        do_store;
    logic        do_eret;
    logic        do_take;

    logic [31:0] reg_val;
    logic [31:0] wr_mask;

    cp0_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .rst      (rst),
        .ir_in    (ir_in),
        .irq_edge (irq_edge)
    );

    // ------------------------------------------------------------------
    // Qualifiers. An interrupt is only taken on a real, non-branch EXE
    // instruction with no CP0 operation, so EPC is always a clean restart
    // point and no delay-slot or MTC0 side effect is lost.
    // ------------------------------------------------------------------
    always_comb begin
        do_store = en && (oper == EXE_CP_STORE);
        do_eret  = en && (oper == EXE_CP0_ERET);
        do_take  = en && (state == CP0_PEND) && status_ie && exe_valid &&
                   !is_branch_exe && !is_branch_mem && (oper == EXE_CP_NONE);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CP0_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                CP0_IDLE: begin
                    if (cause_ip) begin
                        state_nxt = CP0_PEND;
                    end
                end
                CP0_PEND: begin
                    if (do_take) begin
                        state_nxt = CP0_HANDLER;
                    end
                end
                CP0_HANDLER: begin
                    // An interrupt that arrived inside the handler is
                    // already pending, so return straight to PEND.
                    if (do_eret) begin
                        state_nxt = cause_ip ? CP0_PEND : CP0_IDLE;
                    end
                end
                default: state_nxt = CP0_IDLE;
            endcase
        end
    end

    assign in_handler = (state == CP0_HANDLER);

    // ------------------------------------------------------------------
    // CP0 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_ie <= 1'b0;
            cause_ip  <= 1'b0;
            epc       <= 32'h0000_0000;
            ebase     <= EBASE_RST;
        end else if (en) begin
            if (do_store) begin
                case (addr_w)
                    CP0_REG_STATUS: status_ie <= data_w[STATUS_IE];
                    CP0_REG_EPC:    epc       <= data_w;
                    CP0_REG_EBASE:  ebase     <= data_w & cp0_wmask(CP0_REG_EBASE);
                    default:        ;
                endcase
            end
            // Entry clears IP; an edge arriving while IP is set is dropped
            // because there is only one pending slot.
            if (do_take) begin
                epc       <= ret_addr;
                status_ie <= 1'b0;
                cause_ip  <= 1'b0;
            end else if (irq_edge) begin
                cause_ip  <= 1'b1;
            end
            if (do_eret) begin
                status_ie <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Redirect. Take and ERET are mutually exclusive (take needs NONE).
    // jump_en is recomputed every cycle so it can never stretch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_en   <= 1'b0;
            jump_addr <= 32'h0000_0000;
        end else begin
            jump_en <= do_take || do_eret;
            if (do_take) begin
                jump_addr <= ebase;
            end else if (do_eret) begin
                jump_addr <= epc;
            end
        end
    end

    // ------------------------------------------------------------------
    // MFC0 read path with write-through bypass. Only bits that the MTC0
    // would actually change are replaced, so a same-cycle write to CAUSE
    // or an unimplemented index does not alter the read value.
    // ------------------------------------------------------------------
    always_comb begin
        reg_val = 32'h0000_0000;
        case (addr_r)
            CP0_REG_STATUS: reg_val[STATUS_IE] = status_ie;
            CP0_REG_CAUSE:  reg_val[CAUSE_IP]  = cause_ip;
            CP0_REG_EPC:    reg_val            = epc;
            CP0_REG_EBASE:  reg_val            = ebase;
            default:        reg_val            = 32'h0000_0000;
        endcase

        wr_mask = cp0_wmask(addr_r);
        data_r  = reg_val;
        if (do_store && (addr_w == addr_r)) begin
            data_r = (reg_val & ~wr_mask) | (data_w & wr_mask);
        end
    end

endmodule
`default_nettype wire
